// File: rtl/hazard_ctrl_if.sv
// Purpose: groups the hazard controller's hazard/branch/dmem inputs and its stall/flush/perf outputs.
// Latency: n/a (bundle of wires only).
// Backpressure: n/a; master drives the *_i fields, slave (the controller) drives the *_o fields.
// Ports: rs1/rs2 load-use flags, branch redirect, dmem req/ack in; holds, bubbles, flush,
//        fault and three CNT_W-wide perf counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             rs1_lu_hazard_i;
  logic             rs2_lu_hazard_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_hold_o;
  logic             if_id_hold_o;
  logic             if_id_flush_o;
  logic             id_ex_hold_o;
  logic             id_ex_bubble_o;
  logic             ex_mem_hold_o;
  logic             mem_wb_bubble_o;
  logic             mem_fault_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;
  logic [CNT_W-1:0] mem_stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output rs1_lu_hazard_i, rs2_lu_hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_bubble_o,
           ex_mem_hold_o, mem_wb_bubble_o, mem_fault_o,
           lu_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_lu_hazard_i, rs2_lu_hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_bubble_o,
           ex_mem_hold_o, mem_wb_bubble_o, mem_fault_o,
           lu_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline stall/flush controller with saturating perf counters and a sticky dmem-timeout fault.
// Latency: stall/flush outputs are combinational (same cycle); counters and fault update at the next edge.
// Backpressure: an outstanding dmem access freezes the whole pipe; branch/load-use actions wait behind it.
// Ports: clk_i, rst_i (async, active-high) plain; everything else through hazard_ctrl_if.slave.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  // Index of the current wait cycle while in MEM_WAIT (the RUN cycle that
  // started the wait is cycle 1, so the first MEM_WAIT cycle is 2).
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic memw;
  logic freeze;
  logic br_sel;
  logic lu_sel;

  always_comb begin
    memw   = bus.dmem_req_i & ~bus.dmem_ack_i;
    freeze = (state_q != RUN) | memw;
    // A frozen EX keeps presenting the branch/hazard, so both are simply deferred.
    br_sel = ~freeze & bus.branch_taken_i;
    // A taken branch squashes the younger instruction, so its hazard is moot.
    lu_sel = ~freeze & ~bus.branch_taken_i & (bus.rs1_lu_hazard_i | bus.rs2_lu_hazard_i);
  end

  // Control outputs are forced low for the whole time reset is asserted,
  // even though the inputs feeding them may still be toggling.
  always_comb begin
    bus.pc_hold_o       = ~rst_i & (freeze | lu_sel);
    bus.if_id_hold_o    = ~rst_i & (freeze | lu_sel);
    bus.if_id_flush_o   = ~rst_i & br_sel;
    bus.id_ex_hold_o    = ~rst_i & freeze;
    bus.id_ex_bubble_o  = ~rst_i & (br_sel | lu_sel);
    bus.ex_mem_hold_o   = ~rst_i & freeze;
    bus.mem_wb_bubble_o = ~rst_i & freeze;
    bus.mem_fault_o     = (state_q == FAULT);
    bus.lu_stall_cnt_o  = lu_cnt_q;
    bus.mem_stall_cnt_o = mem_cnt_q;
    bus.flush_cnt_o     = flush_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (memw) begin
          // With a limit of one, the very first wait cycle is already the last.
          if (MAX_WAIT == 1) begin
            state_d = FAULT;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(2);
          end
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ack_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = FAULT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FAULT: begin
        wait_d = '0;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Perf counters stick at all-ones rather than wrapping.
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    mem_cnt_d   = mem_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_sel && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + 1'b1;
    end
    if (freeze && (state_q != FAULT) && (mem_cnt_q != '1)) begin
      mem_cnt_d = mem_cnt_q + 1'b1;
    end
    if (br_sel && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      lu_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      lu_cnt_q    <= lu_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl (CNT_W=4, MAX_WAIT=4) against a rule-level model.
// Latency: control outputs checked mid-cycle, counters/fault checked just after each rising edge.
// Backpressure: dmem waits, timeouts, async reset and counter saturation are all exercised.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MAXW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.CNT_W(CW), .MAX_WAIT(MAXW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pipeline is either running, waiting on memory
  // (m_waited = wait cycles already spent) or dead in a timeout fault.
  bit m_wait;
  bit m_fault;
  int m_waited;
  int m_lu;
  int m_mem;
  int m_fl;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit r1, input bit r2, input bit br, input bit rq, input bit ak);
    bus.rs1_lu_hazard_i = r1;
    bus.rs2_lu_hazard_i = r2;
    bus.branch_taken_i  = br;
    bus.dmem_req_i      = rq;
    bus.dmem_ack_i      = ak;
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_fault  = 0;
    m_waited = 0;
    m_lu     = 0;
    m_mem    = 0;
    m_fl     = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk_regs();
    chk("fault", 16'(bus.mem_fault_o), 16'(m_fault));
    chk("lu_cnt", 16'(bus.lu_stall_cnt_o), 16'(m_lu));
    chk("mem_cnt", 16'(bus.mem_stall_cnt_o), 16'(m_mem));
    chk("flush_cnt", 16'(bus.flush_cnt_o), 16'(m_fl));
  endtask

  // One clock with the inputs currently driven (set at posedge+1).
  task automatic cycle();
    bit stuck, brk, lu, acked;
    bit e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh, e_mwb;
    acked = bus.dmem_ack_i;
    stuck = m_fault || m_wait || (bus.dmem_req_i && !acked);
    brk   = !stuck && bus.branch_taken_i;
    lu    = !stuck && !brk && (bus.rs1_lu_hazard_i || bus.rs2_lu_hazard_i);
    e_pc  = stuck || lu;
    e_ifh = stuck || lu;
    e_iff = brk;
    e_idh = stuck;
    e_idb = brk || lu;
    e_exh = stuck;
    e_mwb = stuck;
    @(negedge clk);
    chk("pc_hold", 16'(bus.pc_hold_o), 16'(e_pc));
    chk("if_id_hold", 16'(bus.if_id_hold_o), 16'(e_ifh));
    chk("if_id_flush", 16'(bus.if_id_flush_o), 16'(e_iff));
    chk("id_ex_hold", 16'(bus.id_ex_hold_o), 16'(e_idh));
    chk("id_ex_bubble", 16'(bus.id_ex_bubble_o), 16'(e_idb));
    chk("ex_mem_hold", 16'(bus.ex_mem_hold_o), 16'(e_exh));
    chk("mem_wb_bubble", 16'(bus.mem_wb_bubble_o), 16'(e_mwb));
    // Advance the model by the rules: counters first, from this cycle's decision.
    if (stuck && !m_fault) m_mem = sat_inc(m_mem);
    if (brk) m_fl = sat_inc(m_fl);
    if (lu) m_lu = sat_inc(m_lu);
    if (!m_fault && stuck) begin
      if (acked && m_wait) begin
        m_wait   = 0;
        m_waited = 0;
      end else if (m_waited + 1 >= MAXW) begin
        m_fault  = 1;
        m_wait   = 0;
        m_waited = 0;
      end else begin
        m_wait   = 1;
        m_waited = m_waited + 1;
      end
    end
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_in(1, 1, 1, 1, 0);
    model_reset();
    #2;
    // Reset held with every input active: all controls low, state cleared.
    chk("rst_pc_hold", 16'(bus.pc_hold_o), 16'd0);
    chk("rst_mem_wb_bubble", 16'(bus.mem_wb_bubble_o), 16'd0);
    chk("rst_if_id_flush", 16'(bus.if_id_flush_o), 16'd0);
    chk_regs();
    do_reset();

    // Single-cycle rs1 load-use hazard.
    set_in(1, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0); cycle();
    chk("dir_lu_one", 16'(bus.lu_stall_cnt_o), 16'd1);

    // dmem wait acked on the third frozen cycle.
    do_reset();
    set_in(0, 0, 0, 1, 0); cycle();
    set_in(0, 0, 0, 1, 0); cycle();
    set_in(0, 0, 0, 1, 1); cycle();
    set_in(0, 0, 0, 0, 0); cycle();
    chk("dir_mem_three", 16'(bus.mem_stall_cnt_o), 16'd3);
    chk("dir_mem_nofault", 16'(bus.mem_fault_o), 16'd0);

    // Branch beats a simultaneous rs2 hazard.
    do_reset();
    set_in(0, 1, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0); cycle();
    chk("dir_br_flush", 16'(bus.flush_cnt_o), 16'd1);
    chk("dir_br_lu", 16'(bus.lu_stall_cnt_o), 16'd0);

    // Branch deferred behind a two-cycle dmem wait, then flushes once.
    do_reset();
    set_in(0, 0, 1, 1, 0); cycle();
    set_in(0, 0, 1, 0, 1); cycle();
    set_in(0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0); cycle();
    chk("dir_defer_flush", 16'(bus.flush_cnt_o), 16'd1);
    chk("dir_defer_mem", 16'(bus.mem_stall_cnt_o), 16'd2);

    // No ack: fault after wait cycle MAXW, frozen until reset.
    do_reset();
    for (int i = 0; i < MAXW; i++) begin
      set_in(0, 0, 0, 1, 0); cycle();
    end
    chk("dir_fault_set", 16'(bus.mem_fault_o), 16'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0, 1); cycle();
    end
    chk("dir_fault_memcnt", 16'(bus.mem_stall_cnt_o), 16'(MAXW));

    // Ack on the limit cycle wins.
    do_reset();
    for (int i = 0; i < MAXW - 1; i++) begin
      set_in(0, 0, 0, 1, 0); cycle();
    end
    set_in(0, 0, 0, 1, 1); cycle();
    set_in(0, 0, 0, 0, 0); cycle();
    chk("dir_ack_limit", 16'(bus.mem_fault_o), 16'd0);

    // Saturation of the load-use counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, 0, 0, 0); cycle();
    end
    chk("dir_lu_sat", 16'(bus.lu_stall_cnt_o), 16'(CMAX));

    // Asynchronous reset in the middle of a wait.
    do_reset();
    set_in(0, 0, 0, 1, 0); cycle();
    set_in(0, 0, 0, 1, 0); cycle();
    set_in(1, 1, 1, 1, 0);
    rst = 1'b1;
    #2;
    chk("async_pc_hold", 16'(bus.pc_hold_o), 16'd0);
    chk("async_id_ex_hold", 16'(bus.id_ex_hold_o), 16'd0);
    chk("async_mem_cnt", 16'(bus.mem_stall_cnt_o), 16'd0);
    chk("async_fault", 16'(bus.mem_fault_o), 16'd0);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 0);
      cycle();
      if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
